// File: rtl/ysyx_22040895_pcgen.sv
// Program-counter generator for the ysyx_22040895 front end.
// Presents fetch addresses to the IFU over a valid/ready handshake.
// Accepts trap and branch redirects, with traps taking priority over branches.
// Each applied redirect bumps an epoch tag and raises a one-cycle flush pulse.
// halt_i (ebreak) freezes fetch until the next reset.
module ysyx_22040895_pcgen #(
  parameter int                 XLEN       = 64,
  parameter logic [XLEN-1:0]    RESET_PC   = XLEN'(64'h0000000080000000),
  parameter int                 INST_BYTES = 4,
  parameter int                 EPOCH_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_valid_i,
  input  logic [XLEN-1:0]     br_pc_i,
  input  logic                trap_valid_i,
  input  logic [XLEN-1:0]     trap_pc_i,
  input  logic                halt_i,
  input  logic                fetch_ready_i,
  output logic                fetch_valid_o,
  output logic [XLEN-1:0]     fetch_pc_o,
  output logic [EPOCH_W-1:0]  fetch_epoch_o,
  output logic                misalign_o,
  output logic                flush_o,
  output logic                halted_o
);

  // Number of low pc bits that must be zero for an aligned fetch.
  // INST_BYTES is at least 2, so this is always at least 1.
  localparam int OFF_W = $clog2(INST_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               flush_q, flush_d;

  logic               redir_valid;
  logic [XLEN-1:0]    redir_pc;
  logic               handshake;
  logic [XLEN-1:0]    pc_seq;

  // Pick the winning redirect target: a trap overrides a branch in the same cycle.
  always_comb begin
    redir_valid = 1'b0;
    redir_pc    = pc_q;
    if (trap_valid_i) begin
      redir_valid = 1'b1;
      redir_pc    = trap_pc_i;
    end else if (br_valid_i) begin
      redir_valid = 1'b1;
      redir_pc    = br_pc_i;
    end
  end

  // An address is consumed only while presented as valid, i.e. in RUN.
  assign handshake = (state_q == S_RUN) && fetch_ready_i;
  // Sequential increment wraps naturally modulo 2^XLEN.
  assign pc_seq    = pc_q + XLEN'(INST_BYTES);

  // Next-state and next-pc selection.
  // Priority in RUN is halt, then redirect, then handshake, then hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    flush_d = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        // Redirects arriving while booting are dropped on purpose.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_i) begin
          // Freeze on the current pc; a concurrent redirect is not applied.
          state_d = S_HALT;
        end else if (redir_valid) begin
          // Applied even without ready; a same-cycle handshake still counts,
          // but the next address is the target, not pc+INST_BYTES.
          pc_d    = redir_pc;
          epoch_d = epoch_q + EPOCH_W'(1);
          flush_d = 1'b1;
        end else if (handshake) begin
          pc_d = pc_seq;
        end
      end
      S_HALT: begin
        // Only reset leaves HALT; everything else is ignored.
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State registers with synchronous reset overriding any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      flush_q <= flush_d;
    end
  end

  // All outputs come from registers only; there is no input-to-output path.
  assign fetch_valid_o = (state_q == S_RUN);
  assign halted_o      = (state_q == S_HALT);
  assign fetch_pc_o    = pc_q;
  assign fetch_epoch_o = epoch_q;
  assign flush_o       = flush_q;
  assign misalign_o    = fetch_valid_o && (pc_q[OFF_W-1:0] != '0);

endmodule

// File: tb/tb_ysyx_22040895_pcgen.sv
// Self-checking bench for ysyx_22040895_pcgen.
// A main instance boots at 0x80000000; a second instance boots near the top
// of the address space to exercise pc wrap-around. Both share the stimulus.
module tb_ysyx_22040895_pcgen;

  localparam int XLEN = 64;
  localparam int EW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            br_valid, trap_valid, halt, ready;
  logic [XLEN-1:0] br_pc, trap_pc;

  logic            a_valid, a_mis, a_flush, a_halted;
  logic [XLEN-1:0] a_pc;
  logic [EW-1:0]   a_epoch;
  logic            b_valid, b_mis, b_flush, b_halted;
  logic [XLEN-1:0] b_pc;
  logic [EW-1:0]   b_epoch;

  always #5 clk = ~clk;

  ysyx_22040895_pcgen #(.XLEN(XLEN), .RESET_PC(64'h0000000080000000),
                        .INST_BYTES(4), .EPOCH_W(EW)) u_dut (
    .clk(clk), .rst(rst),
    .br_valid_i(br_valid), .br_pc_i(br_pc),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .halt_i(halt), .fetch_ready_i(ready),
    .fetch_valid_o(a_valid), .fetch_pc_o(a_pc), .fetch_epoch_o(a_epoch),
    .misalign_o(a_mis), .flush_o(a_flush), .halted_o(a_halted)
  );

  ysyx_22040895_pcgen #(.XLEN(XLEN), .RESET_PC(64'hFFFFFFFFFFFFFFFC),
                        .INST_BYTES(4), .EPOCH_W(EW)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .br_valid_i(br_valid), .br_pc_i(br_pc),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .halt_i(halt), .fetch_ready_i(ready),
    .fetch_valid_o(b_valid), .fetch_pc_o(b_pc), .fetch_epoch_o(b_epoch),
    .misalign_o(b_mis), .flush_o(b_flush), .halted_o(b_halted)
  );

  typedef struct {
    logic            rst;
    logic            br;
    logic [XLEN-1:0] br_pc;
    logic            trap;
    logic [XLEN-1:0] trap_pc;
    logic            halt;
    logic            ready;
    logic            e_valid;
    logic [XLEN-1:0] e_pc;
    logic [EW-1:0]   e_epoch;
    logic            e_flush;
    logic            e_halted;
    logic            e_mis;
  } vec_t;

  typedef struct {
    int              step;
    int              which;
    logic            e_valid;
    logic [XLEN-1:0] e_pc;
    logic [EW-1:0]   e_epoch;
    logic            e_flush;
    logic            e_halted;
    logic            e_mis;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic r, input logic b, input logic [XLEN-1:0] bp,
                              input logic t, input logic [XLEN-1:0] tp,
                              input logic h, input logic rd,
                              input logic ev, input logic [XLEN-1:0] epc,
                              input logic [EW-1:0] eep, input logic efl,
                              input logic eh, input logic em);
    vec_t v;
    v.rst = r; v.br = b; v.br_pc = bp; v.trap = t; v.trap_pc = tp;
    v.halt = h; v.ready = rd;
    v.e_valid = ev; v.e_pc = epc; v.e_epoch = eep;
    v.e_flush = efl; v.e_halted = eh; v.e_mis = em;
    return v;
  endfunction

  task automatic chk1(input string name, input int s, input logic [XLEN-1:0] got,
                      input logic [XLEN-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s: got %h want %h", s, name, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, and check after the edge.
  task automatic step(input vec_t v, input int which);
    exp_t e, got;
    rst = v.rst; br_valid = v.br; br_pc = v.br_pc;
    trap_valid = v.trap; trap_pc = v.trap_pc; halt = v.halt; ready = v.ready;
    e.step = step_no; e.which = which;
    e.e_valid = v.e_valid; e.e_pc = v.e_pc; e.e_epoch = v.e_epoch;
    e.e_flush = v.e_flush; e.e_halted = v.e_halted; e.e_mis = v.e_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.which == 0) begin
      chk1("valid",  got.step, XLEN'(a_valid),  XLEN'(got.e_valid));
      chk1("pc",     got.step, a_pc,            got.e_pc);
      chk1("epoch",  got.step, XLEN'(a_epoch),  XLEN'(got.e_epoch));
      chk1("flush",  got.step, XLEN'(a_flush),  XLEN'(got.e_flush));
      chk1("halted", got.step, XLEN'(a_halted), XLEN'(got.e_halted));
      chk1("misal",  got.step, XLEN'(a_mis),    XLEN'(got.e_mis));
    end else begin
      chk1("w_valid",  got.step, XLEN'(b_valid),  XLEN'(got.e_valid));
      chk1("w_pc",     got.step, b_pc,            got.e_pc);
      chk1("w_epoch",  got.step, XLEN'(b_epoch),  XLEN'(got.e_epoch));
      chk1("w_flush",  got.step, XLEN'(b_flush),  XLEN'(got.e_flush));
      chk1("w_halted", got.step, XLEN'(b_halted), XLEN'(got.e_halted));
      chk1("w_misal",  got.step, XLEN'(b_mis),    XLEN'(got.e_mis));
    end
    $display("step%0d dut%0d rst=%0b br=%0b trap=%0b halt=%0b rdy=%0b -> exp pc=%h ep=%0d",
             got.step, got.which, v.rst, v.br, v.trap, v.halt, v.ready, got.e_pc, got.e_epoch);
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    localparam logic [XLEN-1:0] Z = '0;
    localparam logic [XLEN-1:0] B = 64'h0000000080000000;

    // rst br br_pc trap trap_pc halt rdy | valid pc epoch flush halted misal
    tbl.push_back(mk(1,0,Z,0,Z,0,0, 0,B,       0,0,0,0)); // reset values
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B,       0,0,0,0)); // BOOT -> RUN
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+4,     0,0,0,0));
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+8,     0,0,0,0));
    tbl.push_back(mk(0,0,Z,0,Z,0,0, 1,B+8,     0,0,0,0)); // back-pressure
    tbl.push_back(mk(0,0,Z,0,Z,0,0, 1,B+8,     0,0,0,0));
    tbl.push_back(mk(0,0,Z,0,Z,0,0, 1,B+8,     0,0,0,0));
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+'hC,   0,0,0,0));
    tbl.push_back(mk(0,1,B+'h1000,1,B+'h100,0,1, 1,B+'h100,1,1,0,0)); // trap beats branch
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+'h104, 1,0,0,0));
    tbl.push_back(mk(0,1,B+'h102,0,Z,0,0, 1,B+'h102,2,1,0,1)); // misaligned, no ready
    tbl.push_back(mk(0,0,Z,0,Z,0,0, 1,B+'h102, 2,0,0,1));
    tbl.push_back(mk(0,0,Z,1,B+'h200,0,0, 1,B+'h200,3,1,0,0));
    tbl.push_back(mk(0,1,B+'h300,0,Z,0,1, 1,B+'h300,0,1,0,0)); // epoch wraps 3->0
    tbl.push_back(mk(0,1,B+'h8,0,Z,0,1,   1,B+'h8,  1,1,0,0)); // back-to-back redirect
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+'hC,   1,0,0,0));
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+'h10,  1,0,0,0));
    tbl.push_back(mk(0,1,B+'h1000,0,Z,1,1, 0,B+'h10,1,0,1,0)); // halt beats branch
    tbl.push_back(mk(0,1,B+'h1000,1,B+'h400,0,1, 0,B+'h10,1,0,1,0)); // ignored in HALT
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 0,B+'h10,  1,0,1,0));
    tbl.push_back(mk(1,1,B+'h2000,0,Z,0,1, 0,B, 0,0,0,0)); // rst leaves HALT
    tbl.push_back(mk(0,1,B+'h5000,0,Z,0,1, 1,B, 0,0,0,0)); // redirect ignored in BOOT
    tbl.push_back(mk(0,0,Z,0,Z,0,1, 1,B+4,     0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 0);

    // Reset mid-RUN with a trap pending: reset wins.
    step(mk(0,0,Z,0,Z,0,1, 1,B+8, 0,0,0,0), 0);
    step(mk(1,0,Z,1,B+'h700,0,1, 0,B, 0,0,0,0), 0);
    step(mk(0,0,Z,0,Z,0,0, 1,B, 0,0,0,0), 0);
    step(mk(0,0,Z,1,B+'h20,0,0, 1,B+'h20, 1,1,0,0), 0);
    step(mk(0,0,Z,0,Z,0,0, 1,B+'h20, 1,0,0,0), 0);

    // Wrap-around instance: top-of-memory pc increments to zero.
    step(mk(1,0,Z,0,Z,0,1, 0,64'hFFFFFFFFFFFFFFFC, 0,0,0,0), 1);
    step(mk(0,0,Z,0,Z,0,1, 1,64'hFFFFFFFFFFFFFFFC, 0,0,0,0), 1);
    step(mk(0,0,Z,0,Z,0,1, 1,64'h0,                0,0,0,0), 1);
    step(mk(0,0,Z,0,Z,0,1, 1,64'h4,                0,0,0,0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
